// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Stall/flush sequencing for load-use hazards, taken branches and
//            the multi-cycle mul/div unit, with a watchdog on mul/div ops.
//            Define HAZARD_PERF_CNT_EN to add saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MD_TIMEOUT     = 64,
  parameter int REG_ADDR_WIDTH = 5
`ifdef HAZARD_PERF_CNT_EN
  ,parameter int CNT_WIDTH     = 32
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      MemRead_EX_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_EX_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_ID_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_ID_i,
  input  logic                      rs1_used_ID_i,
  input  logic                      rs2_used_ID_i,
  input  logic                      branch_taken_EX_i,
  input  logic                      md_req_EX_i,
  input  logic                      md_done_i,
  output logic                      stall_IF_o,
  output logic                      stall_ID_o,
  output logic                      stall_EX_o,
  output logic                      flush_ID_o,
  output logic                      flush_EX_o,
  output logic                      bubble_MEM_o,
  output logic                      md_start_o,
  output logic                      md_busy_o,
  output logic                      md_timeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [CNT_WIDTH-1:0]     load_use_cnt_o,
  output logic [CNT_WIDTH-1:0]      md_stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
`endif
);

  localparam int WD_W = $clog2(MD_TIMEOUT);
  localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              md_timeout_q, md_timeout_d;
  logic              load_use;

  assign load_use = MemRead_EX_i && (rd_addr_EX_i != '0) &&
                    ((rs1_used_ID_i && (rd_addr_EX_i == rs1_addr_ID_i)) ||
                     (rs2_used_ID_i && (rd_addr_EX_i == rs2_addr_ID_i)));

  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    md_timeout_d = md_timeout_q;
    stall_IF_o   = 1'b0;
    stall_ID_o   = 1'b0;
    stall_EX_o   = 1'b0;
    flush_ID_o   = 1'b0;
    flush_EX_o   = 1'b0;
    bubble_MEM_o = 1'b0;
    md_start_o   = 1'b0;
    md_busy_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_req_EX_i) begin
          md_start_o   = 1'b1;
          stall_IF_o   = 1'b1;
          stall_ID_o   = 1'b1;
          stall_EX_o   = 1'b1;
          bubble_MEM_o = 1'b1;
          wdog_d       = '0;
          state_d      = MD_WAIT;
        end else if (branch_taken_EX_i) begin
          // The ID instruction is discarded, so a pending load-use is moot.
          flush_ID_o = 1'b1;
          flush_EX_o = 1'b1;
        end else if (load_use) begin
          stall_IF_o = 1'b1;
          stall_ID_o = 1'b1;
          flush_EX_o = 1'b1;
        end
      end
      MD_WAIT: begin
        md_busy_o = 1'b1;
        if (md_done_i || (wdog_q == C_WD_LAST)) begin
          // Release: the result (or whatever the unit holds) latches into EX/MEM.
          wdog_d  = '0;
          state_d = IDLE;
          if (!md_done_i) begin
            md_timeout_d = 1'b1;
          end
        end else begin
          stall_IF_o   = 1'b1;
          stall_ID_o   = 1'b1;
          stall_EX_o   = 1'b1;
          bubble_MEM_o = 1'b1;
          wdog_d       = wdog_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  assign md_timeout_o = md_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_WIDTH-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_WIDTH-1:0] fl_cnt_q, fl_cnt_d;

  // stall_ID without stall_EX only occurs for load-use; stall_EX only for mul/div.
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    md_cnt_d = md_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (stall_ID_o && !stall_EX_o && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + CNT_WIDTH'(1);
    if (stall_EX_o && (md_cnt_q != '1))                 md_cnt_d = md_cnt_q + CNT_WIDTH'(1);
    if (flush_ID_o && (fl_cnt_q != '1))                 fl_cnt_d = fl_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lu_cnt_q <= '0;
      md_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      md_cnt_q <= md_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign load_use_cnt_o = lu_cnt_q;
  assign md_stall_cnt_o = md_cnt_q;
  assign flush_cnt_o    = fl_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed-vector scoreboard bench for hazard_ctrl (MD_TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       MemRead_EX_i = 1'b0;
  logic [4:0] rd_addr_EX_i = '0, rs1_addr_ID_i = '0, rs2_addr_ID_i = '0;
  logic       rs1_used_ID_i = 1'b0, rs2_used_ID_i = 1'b0;
  logic       branch_taken_EX_i = 1'b0, md_req_EX_i = 1'b0, md_done_i = 1'b0;
  logic       stall_IF_o, stall_ID_o, stall_EX_o, flush_ID_o, flush_EX_o;
  logic       bubble_MEM_o, md_start_o, md_busy_o, md_timeout_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] load_use_cnt_o, md_stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.MD_TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_EX_i(MemRead_EX_i), .rd_addr_EX_i(rd_addr_EX_i),
    .rs1_addr_ID_i(rs1_addr_ID_i), .rs2_addr_ID_i(rs2_addr_ID_i),
    .rs1_used_ID_i(rs1_used_ID_i), .rs2_used_ID_i(rs2_used_ID_i),
    .branch_taken_EX_i(branch_taken_EX_i), .md_req_EX_i(md_req_EX_i),
    .md_done_i(md_done_i),
    .stall_IF_o(stall_IF_o), .stall_ID_o(stall_ID_o), .stall_EX_o(stall_EX_o),
    .flush_ID_o(flush_ID_o), .flush_EX_o(flush_EX_o), .bubble_MEM_o(bubble_MEM_o),
    .md_start_o(md_start_o), .md_busy_o(md_busy_o), .md_timeout_o(md_timeout_o)
`ifdef HAZARD_PERF_CNT_EN
    ,.load_use_cnt_o(load_use_cnt_o), .md_stall_cnt_o(md_stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
`endif
  );

  // Vector bit order: {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, bubble_MEM,
  //                    md_start, md_busy, md_timeout}
  localparam logic [8:0] C_IDLE = 9'b000_000_000;
  localparam logic [8:0] C_LU   = 9'b110_010_000;
  localparam logic [8:0] C_BR   = 9'b000_110_000;
  localparam logic [8:0] C_ST   = 9'b111_001_100;
  localparam logic [8:0] C_WT   = 9'b111_001_010;
  localparam logic [8:0] C_RL   = 9'b000_000_010;
  localparam logic [8:0] C_TO   = 9'b000_000_001;

  typedef struct {
    logic [8:0] v;
    bit         chk;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_checks = 0;
  int   n_fail   = 0;

  wire [8:0] act = {stall_IF_o, stall_ID_o, stall_EX_o, flush_ID_o, flush_EX_o,
                    bubble_MEM_o, md_start_o, md_busy_o, md_timeout_o};

  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      if (m.chk) begin
        n_checks++;
        if (act !== m.v) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b", m.name, act, m.v);
        end
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic mr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic br,
                      input logic req, input logic done, input bit chk,
                      input logic [8:0] e);
    exp_t t;
    @(posedge clk_i);
    #1;
    rst_i = rst; MemRead_EX_i = mr; rd_addr_EX_i = rd;
    rs1_addr_ID_i = rs1; rs2_addr_ID_i = rs2;
    rs1_used_ID_i = u1; rs2_used_ID_i = u2;
    branch_taken_EX_i = br; md_req_EX_i = req; md_done_i = done;
    t.v = e; t.chk = chk; t.name = name;
    sb.push_back(t);
  endtask

  task automatic md(input string name, input logic req, input logic done, input logic [8:0] e);
    step(name, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, req, done, 1'b1, e);
  endtask

  task automatic lu(input string name, input logic br, input logic [8:0] e);
    step(name, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, br, 1'b0, 1'b0, 1'b1, e);
  endtask

  initial begin
    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, C_IDLE);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, C_IDLE);
    md("reset_idle", 0, 0, C_IDLE);

    lu("lu_rs1", 0, C_LU);
    md("lu_cleared", 0, 0, C_IDLE);
    step("lu_rs1_unused", 0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 1'b1, C_IDLE);
    step("lu_rd0", 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1'b1, C_IDLE);
    step("lu_rs2", 0, 1, 7, 3, 7, 0, 1, 0, 0, 0, 1'b1, C_LU);
    step("no_memread", 0, 0, 7, 7, 7, 1, 1, 0, 0, 0, 1'b1, C_IDLE);
    lu("branch_over_lu", 1, C_BR);
    md("done_in_idle", 0, 1, C_IDLE);

    // mul/div with done 4 cycles after start; a branch mid-wait is ignored
    md("md_start", 1, 0, C_ST);
    md("md_wait1", 1, 0, C_WT);
    step("md_wait2_br", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1'b1, C_WT);
    md("md_wait3", 1, 0, C_WT);
    md("md_release", 1, 1, C_RL);
    md("md_after", 0, 0, C_IDLE);

    // back-to-back, first latency 2: starts 3 cycles apart
    md("b2b_start_a", 1, 0, C_ST);
    md("b2b_wait_a", 1, 0, C_WT);
    md("b2b_rel_a", 1, 1, C_RL);
    md("b2b_start_b", 1, 0, C_ST);
    md("b2b_wait_b", 1, 0, C_WT);
    md("b2b_rel_b", 1, 1, C_RL);
    md("b2b_after", 0, 0, C_IDLE);

    // watchdog: 7 waiting cycles then forced release on the 8th MD_WAIT cycle
    md("to_start", 1, 0, C_ST);
    for (int i = 0; i < 7; i++) md("to_wait", 1, 0, C_WT);
    md("to_release", 1, 0, C_RL);
    md("to_sticky", 0, 0, C_TO);
    md("to_done_idle", 0, 1, C_TO);
    lu("to_lu_sticky", 0, C_LU | C_TO);

    // reset on the 2nd MD_WAIT cycle
    md("rst_start", 1, 0, C_ST | C_TO);
    md("rst_wait1", 1, 0, C_WT | C_TO);
    step("rst_apply", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1'b0, C_IDLE);
    md("rst_after", 0, 0, C_IDLE);
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk_i);
    n_checks++;
    if ({load_use_cnt_o, md_stall_cnt_o, flush_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL perf_cnt_reset: got %0d/%0d/%0d expected 0/0/0",
               load_use_cnt_o, md_stall_cnt_o, flush_cnt_o);
    end
`endif
    md("rst_idle", 0, 0, C_IDLE);

    repeat (3) @(negedge clk_i);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
